// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: request fields with a valid/ready
// handshake in, packed instruction with a valid/ready handshake out.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  immsrc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;

    modport master (
        output in_valid, immsrc, imm, opcode, rd, rs1, rs2, funct3, out_ready,
        input  in_ready, out_valid, out_instr, out_err, err_count
    );

    modport slave (
        input  in_valid, immsrc, imm, opcode, rd, rs1, rs2, funct3, out_ready,
        output in_ready, out_valid, out_instr, out_err, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction packer (I/S/B/J immediates) with range flagging.
// Optional saturating error counter enabled by `define INSTR_ENCODER_ERR_COUNT_EN.
module instr_encoder (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } fmt_e;

    fmt_e        fmt;
    logic [31:0] pack_word;
    logic        pack_err;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_instr_q, s1_instr_d;
    logic        s1_err_q,   s1_err_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q, s2_instr_d;
    logic        s2_err_q,   s2_err_d;

    logic s2_adv;
    logic accept;

    assign fmt = fmt_e'(bus.immsrc);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pack_word = '0;
        pack_err  = 1'b0;
        case (fmt)
            FMT_I: begin
                pack_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                pack_err  = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            end
            FMT_S: begin
                pack_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
                pack_err  = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            end
            FMT_B: begin
                pack_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                             bus.imm[4:1], bus.imm[11], bus.opcode};
                pack_err  = bus.imm[0] || !((&bus.imm[31:12]) || !(|bus.imm[31:12]));
            end
            default: begin
                pack_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                             bus.rd, bus.opcode};
                pack_err  = bus.imm[0] || !((&bus.imm[31:20]) || !(|bus.imm[31:20]));
            end
        endcase
    end

    // in_ready depends only on stage flags and out_ready, never on in_valid.
    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s2_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = s1_instr_q;
                s2_err_d   = s1_err_q;
            end
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_instr_d = pack_word;
            s1_err_d   = pack_err;
        end else if (s1_valid_q && s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
        end
    end

    // NOTE: S1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_instr_q <= s1_instr_d;
        s1_err_q   <= s1_err_d;
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_instr = s2_instr_q;
    assign bus.out_err   = s2_err_q;

`ifdef INSTR_ENCODER_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (s2_valid_q && bus.out_ready && s2_err_q && (err_count_q != 16'hFFFF))
            err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_count_q <= '0;
        else       err_count_q <= err_count_d;
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = 16'h0000;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, range errors,
// backpressure, randomized traffic against an arithmetic reference, mid-flight reset.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_encoder_if bus();
    instr_encoder dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];
    int err_seen = 0;
    int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: range from signed bounds, packing by shift-and-mask of immediate slices.
    function automatic logic [32:0] model(input logic [1:0] fmt, input logic [31:0] imm,
                                          input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3);
        int v;
        logic [31:0] w;
        logic e;
        v = $signed(imm);
        w = 32'(op);
        e = 1'b0;
        case (fmt)
            2'd0: begin
                e = (v < -2048) || (v > 2047);
                w = w | ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
            end
            2'd1: begin
                e = (v < -2048) || (v > 2047);
                w = w | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                      | (32'(f3) << 12) | ((imm & 32'h1F) << 7);
            end
            2'd2: begin
                e = (imm[0] == 1'b1) || (v < -4096) || (v > 4095);
                w = w | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            end
            default: begin
                e = (imm[0] == 1'b1) || (v < -1048576) || (v > 1048575);
                w = w | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (32'(rd) << 7);
            end
        endcase
        return {e, w};
    endfunction

    function automatic logic [31:0] exp_err_count();
`ifdef INSTR_ENCODER_ERR_COUNT_EN
        return (err_seen > 65535) ? 32'hFFFF : 32'(err_seen);
`else
        return 32'h0;
`endif
    endfunction

    task automatic drive(input logic v, input logic [1:0] fmt, input logic [31:0] imm,
                         input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3);
        bus.in_valid = v;
        bus.immsrc   = fmt;
        bus.imm      = imm;
        bus.opcode   = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.funct3   = f3;
    endtask

    // Called just after a falling edge; observes both handshakes, then crosses one rising edge.
    task automatic step();
        logic acc;
        logic [32:0] e;
        logic [32:0] e_in;
        #1;
        acc  = bus.in_valid && bus.in_ready;
        e_in = model(bus.immsrc, bus.imm, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(bus.out_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("out_instr", bus.out_instr, e[31:0]);
                check("out_err", 32'(bus.out_err), 32'(e[32]));
                if (e[32]) err_seen++;
            end
        end
        @(posedge clk);
        if (acc) exp_q.push_back(e_in);
        @(negedge clk);
    endtask

    task automatic run_one(input string tag, input logic [1:0] fmt, input logic [31:0] imm,
                           input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [31:0] exp_instr, input logic exp_err);
        drive(1'b1, fmt, imm, op, rd, rs1, rs2, f3);
        step();
        bus.in_valid = 1'b0;
        check({tag, "_lat_early"}, 32'(bus.out_valid), 32'h0);
        step();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
        check({tag, "_instr"}, bus.out_instr, exp_instr);
        check({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
        step();
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'(int'($urandom_range(0, 8191)) - 4096);
            2: return 32'(int'($urandom_range(0, 4194303)) - 2097152);
            default: return 32'(bnd[$urandom_range(0, 11)] + int'($urandom_range(0, 1)));
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] first;

        reset = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_err", 32'(bus.out_err), 32'h0);
        check("rst_err_count", 32'(bus.err_count), 32'h0);

        run_one("i_type", 2'b00, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF00093, 1'b0);
        run_one("s_type", 2'b01, 32'd8,        7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'h0020A423, 1'b0);
        run_one("b_type", 2'b10, 32'hFFFFFFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE000EE3, 1'b0);
        run_one("j_type", 2'b11, 32'h800,      7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h001000EF, 1'b0);
        run_one("i_range", 2'b00, 32'h800,     7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h80000013, 1'b1);
        run_one("b_odd", 2'b10, 32'd3,         7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000163, 1'b1);
`ifdef INSTR_ENCODER_ERR_COUNT_EN
        check("err_count_two", 32'(bus.err_count), 32'h2);
`else
        check("err_count_tied", 32'(bus.err_count), 32'h0);
`endif

        // Backpressure: three offered, two accepted, output frozen.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd5,   7'h13, 5'd3, 5'd4, 5'd0, 3'd1);
        step();
        drive(1'b1, 2'b01, 32'd100, 7'h23, 5'd0, 5'd6, 5'd7, 3'd2);
        step();
        drive(1'b1, 2'b11, 32'd2048, 7'h6F, 5'd9, 5'd0, 5'd0, 3'd0);
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        first = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid_hold", 32'(bus.out_valid), 32'h1);
            check("bp_instr_hold", bus.out_instr, first[31:0]);
            check("bp_err_hold", 32'(bus.out_err), 32'(first[32]));
            check("bp_in_ready_hold", 32'(bus.in_ready), 32'h0);
            check("bp_occupancy", 32'(exp_q.size()), 32'd2);
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("rel_valid_1", 32'(bus.out_valid), 32'h1);
        step();
        check("rel_valid_2", 32'(bus.out_valid), 32'h1);
        step();
        check("rel_valid_3", 32'(bus.out_valid), 32'h0);
        check("rel_drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_imm(),
                  7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("rand_drain", 32'(exp_q.size()), 32'd0);
        check("rand_err_count", 32'(bus.err_count), exp_err_count());

        // Reset with two entries in flight.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h800, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0);
        step();
        drive(1'b1, 2'b10, 32'd7, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0);
        step();
        bus.in_valid = 1'b0;
        check("mid_occupancy", 32'(exp_q.size()), 32'd2);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_instr", bus.out_instr, 32'h0);
        check("mid_rst_err_count", 32'(bus.err_count), 32'h0);
        exp_q.delete();
        err_seen = 0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_stale", 32'(bus.out_valid), 32'h0);
        end
        run_one("post_rst", 2'b00, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF00093, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
